bf_array_core: RTL and testbench
================================

Name: bf_array_core

Overview:
Parametrised beamformer array core. It applies per-channel, per-source complex weights to N_SRC baseband I/Q sources and sums them per channel. Each channel's result is up-mixed with the fs/4 quadrature LO into a real sample per channel; those outputs feed the per-channel DSM stages. New in this generation:
- runtime weight loading through a valid/ready port into a shadow bank;
- a glitch-free commit of the shadow bank to the active bank, aligned to the LO phase-0 boundary;
- a clock-enable stall.

Parameters:
N_CH, 8, number of output channels (antenna elements)
N_SRC, 2, number of I/Q source beams summed per channel
IN_W, 8, signed width of each source I and Q sample
W_W, 5, signed width of each weight (cos and sin)
OUT_W, 20, signed width of each mixed output; must satisfy OUT_W >= IN_W+W_W+2+clog2(N_SRC)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
en  in  1  pipeline/LO advance enable; low = full stall
vin_i  in  N_SRC*IN_W  source I samples, source s at [s*IN_W +: IN_W], signed
vin_q  in  N_SRC*IN_W  source Q samples, same packing
wl_valid  in  1  weight write request
wl_ready  out  1  weight port can accept
wl_ch  in  clog2(N_CH)  target channel
wl_src  in  max(1,clog2(N_SRC))  target source
wl_cos  in  W_W  signed cos weight
wl_sin  in  W_W  signed sin weight
wl_commit  in  1  request shadow-to-active copy
commit_done  out  1  one-cycle pulse when active bank updated
wl_err  out  1  one-cycle pulse on out-of-range write address
mix_o  out  N_CH*OUT_W  real mixed outputs, channel c at [c*OUT_W +: OUT_W], signed
out_valid  out  1  mix_o holds a valid sample
lo_phase  out  2  LO phase applied to the current mix_o

Behaviour:
Reset: all outputs are 0 (wl_ready is 0 during reset and 1 from the first cycle after). Shadow and active weights, pipeline registers and the LO counter are all cleared.

LO counter:
- 2-bit, increments by 1 on each cycle with en=1 and wraps 3->0.
- Mix rule per phase: 0: +I, 1: +Q, 2: -I, 3: -Q.

Pipeline (advances only when en=1; when en=0 every register, including out_valid, holds):
- S1: register vin_i and vin_q.
- S2: per channel c, sum over s:
  - I_c = sum(vi_s*cos[c][s] - vq_s*sin[c][s])
  - Q_c = sum(vi_s*sin[c][s] + vq_s*cos[c][s])
  - Full-precision signed arithmetic, sign-extended to OUT_W. Registered. Uses the active bank.
- S3: select or negate I_c / Q_c according to the current LO counter, and register into mix_o. lo_phase is registered alongside.
- Latency: an input sampled at enabled edge k appears on mix_o after enabled edge k+2, i.e. 3 enabled cycles.
- out_valid rises after the third enabled cycle following reset and then stays 1 until reset.
- The OUT_W constraint guarantees negation cannot overflow; no saturation logic is required.

Weight-load FSM (states IDLE, PEND):
- IDLE:
  - wl_ready=1.
  - wl_valid && wl_ready with wl_ch<N_CH and wl_src<N_SRC: writes the shadow entry.
  - Out-of-range address: the write is dropped and wl_err pulses.
  - wl_commit moves the FSM to PEND. A write and a commit in the same cycle: the write lands first and is included in the commit.
- PEND:
  - wl_ready=0; writes are not accepted and wl_commit is ignored.
  - On a cycle with en=1 and LO counter==3, the shadow bank copies into the active bank at that edge, commit_done pulses the following cycle, and the FSM returns to IDLE.
  - The first S2 result computed with the new weights is mixed at phase 0.
  - With en=0 the FSM waits in PEND indefinitely.
- The active bank never changes outside a commit. The shadow bank persists after a commit.
- Reset mid-PEND: the commit is abandoned and both banks clear.

Test Plan:
- Reset, en=1, no weights loaded, vin_i=vin_q=0x10 -> mix_o all 0, out_valid=1 from cycle 3, lo_phase cycles 0,1,2,3.
- Load ch0/src0 cos=15 sin=0, commit; then vin_i[0]=10, vin_q[0]=3 -> commit_done pulses at an LO 3->0 edge; mix_o[ch0] sequence 150,45,-150,-45; other channels 0.
- Load ch2/src1 cos=0 sin=-16 with vin_i[1]=-128, vin_q[1]=127 -> I=2032, Q=2048; ch2 output cycles 2032,2048,-2032,-2048.
- Commit issued at LO phase 0 -> wl_ready low for 4 enabled cycles; a wl_valid during PEND is not accepted; the active bank changes exactly once.
- Hold en=0 for 5 cycles mid-stream -> mix_o, lo_phase and out_valid are frozen; the sequence resumes unchanged.
- wl_ch=N_CH (with N_CH=6 build) -> wl_err pulses, no bank change; a simultaneous valid write plus commit -> the written weight is active after commit_done.

Source files
------------

// File: rtl/bf_array_core.sv
// Beamformer array core: per-channel complex weighting of N_SRC I/Q beams, fs/4 up-mix,
// and a shadow/active weight bank whose commit is aligned to the LO phase-0 boundary.
module bf_array_core #(
    parameter int N_CH  = 8,
    parameter int N_SRC = 2,
    parameter int IN_W  = 8,
    parameter int W_W   = 5,
    parameter int OUT_W = 20,
    localparam int CH_W  = (N_CH  > 1) ? $clog2(N_CH)  : 1,
    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        en,
    input  logic [N_SRC*IN_W-1:0]       vin_i,
    input  logic [N_SRC*IN_W-1:0]       vin_q,
    input  logic                        wl_valid,
    output logic                        wl_ready,
    input  logic [CH_W-1:0]             wl_ch,
    input  logic [SRC_W-1:0]            wl_src,
    input  logic signed [W_W-1:0]       wl_cos,
    input  logic signed [W_W-1:0]       wl_sin,
    input  logic                        wl_commit,
    output logic                        commit_done,
    output logic                        wl_err,
    output logic [N_CH*OUT_W-1:0]       mix_o,
    output logic                        out_valid,
    output logic [1:0]                  lo_phase
);

    typedef enum logic {IDLE, PEND} state_t;

    state_t state_q, state_d;

    logic [1:0]              lo_q, lo_d;
    logic [N_SRC*IN_W-1:0]   vi_q, vi_d, vq_q, vq_d;
    logic signed [OUT_W-1:0] sum_i_q [N_CH];
    logic signed [OUT_W-1:0] sum_i_d [N_CH];
    logic signed [OUT_W-1:0] sum_q_q [N_CH];
    logic signed [OUT_W-1:0] sum_q_d [N_CH];
    logic [N_CH*OUT_W-1:0]   mix_q, mix_d;
    logic [1:0]              phase_q, phase_d;
    logic [2:0]              vld_q, vld_d;
    logic                    commit_done_q, commit_done_d;
    logic                    wl_err_q, wl_err_d;

    logic signed [W_W-1:0]   sh_cos_q  [N_CH][N_SRC];
    logic signed [W_W-1:0]   sh_cos_d  [N_CH][N_SRC];
    logic signed [W_W-1:0]   sh_sin_q  [N_CH][N_SRC];
    logic signed [W_W-1:0]   sh_sin_d  [N_CH][N_SRC];
    logic signed [W_W-1:0]   act_cos_q [N_CH][N_SRC];
    logic signed [W_W-1:0]   act_cos_d [N_CH][N_SRC];
    logic signed [W_W-1:0]   act_sin_q [N_CH][N_SRC];
    logic signed [W_W-1:0]   act_sin_d [N_CH][N_SRC];

    logic wr_fire;
    logic addr_hit;
    logic commit_now;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (wl_commit) state_d = PEND;
            PEND: if (commit_now) state_d = IDLE;
        endcase
    end

    always_comb begin
        wl_ready   = (state_q == IDLE) && !reset;
        commit_now = (state_q == PEND) && en && (lo_q == 2'd3);
    end

    assign wr_fire = wl_valid && wl_ready;

    // The copy lands on the edge that wraps the LO to phase 0.
    always_comb begin
        addr_hit  = 1'b0;
        sh_cos_d  = sh_cos_q;
        sh_sin_d  = sh_sin_q;
        act_cos_d = act_cos_q;
        act_sin_d = act_sin_q;
        for (int c = 0; c < N_CH; c++) begin
            for (int s = 0; s < N_SRC; s++) begin
                if (wl_ch == CH_W'(c) && wl_src == SRC_W'(s)) begin
                    addr_hit = 1'b1;
                    if (wr_fire) begin
                        sh_cos_d[c][s] = wl_cos;
                        sh_sin_d[c][s] = wl_sin;
                    end
                end
            end
        end
        if (commit_now) begin
            act_cos_d = sh_cos_q;
            act_sin_d = sh_sin_q;
        end
        wl_err_d      = wr_fire && !addr_hit;
        commit_done_d = commit_now;
    end

    // S2 reads the next-state bank so the result registered on the commit edge is mixed at phase 0.
    always_comb begin
        logic signed [OUT_W-1:0] xi, xq, wc, ws, acc_i, acc_q;
        lo_d = en ? lo_q + 2'd1 : lo_q;
        vi_d = en ? vin_i : vi_q;
        vq_d = en ? vin_q : vq_q;
        for (int c = 0; c < N_CH; c++) begin
            acc_i = '0;
            acc_q = '0;
            for (int s = 0; s < N_SRC; s++) begin
                xi = {{(OUT_W-IN_W){vi_q[s*IN_W+IN_W-1]}}, vi_q[s*IN_W +: IN_W]};
                xq = {{(OUT_W-IN_W){vq_q[s*IN_W+IN_W-1]}}, vq_q[s*IN_W +: IN_W]};
                wc = {{(OUT_W-W_W){act_cos_d[c][s][W_W-1]}}, act_cos_d[c][s]};
                ws = {{(OUT_W-W_W){act_sin_d[c][s][W_W-1]}}, act_sin_d[c][s]};
                acc_i = acc_i + xi * wc - xq * ws;
                acc_q = acc_q + xi * ws + xq * wc;
            end
            sum_i_d[c] = en ? acc_i : sum_i_q[c];
            sum_q_d[c] = en ? acc_q : sum_q_q[c];
        end
    end

    always_comb begin
        mix_d   = mix_q;
        phase_d = phase_q;
        vld_d   = vld_q;
        if (en) begin
            phase_d = lo_q;
            vld_d   = {vld_q[1:0], 1'b1};
            for (int c = 0; c < N_CH; c++) begin
                case (lo_q)
                    2'd0:    mix_d[c*OUT_W +: OUT_W] = sum_i_q[c];
                    2'd1:    mix_d[c*OUT_W +: OUT_W] = sum_q_q[c];
                    2'd2:    mix_d[c*OUT_W +: OUT_W] = -sum_i_q[c];
                    default: mix_d[c*OUT_W +: OUT_W] = -sum_q_q[c];
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lo_q          <= '0;
            vi_q          <= '0;
            vq_q          <= '0;
            sum_i_q       <= '{default: '0};
            sum_q_q       <= '{default: '0};
            mix_q         <= '0;
            phase_q       <= '0;
            vld_q         <= '0;
            commit_done_q <= 1'b0;
            wl_err_q      <= 1'b0;
            sh_cos_q      <= '{default: '0};
            sh_sin_q      <= '{default: '0};
            act_cos_q     <= '{default: '0};
            act_sin_q     <= '{default: '0};
        end else begin
            lo_q          <= lo_d;
            vi_q          <= vi_d;
            vq_q          <= vq_d;
            sum_i_q       <= sum_i_d;
            sum_q_q       <= sum_q_d;
            mix_q         <= mix_d;
            phase_q       <= phase_d;
            vld_q         <= vld_d;
            commit_done_q <= commit_done_d;
            wl_err_q      <= wl_err_d;
            sh_cos_q      <= sh_cos_d;
            sh_sin_q      <= sh_sin_d;
            act_cos_q     <= act_cos_d;
            act_sin_q     <= act_sin_d;
        end
    end

    assign mix_o       = mix_q;
    assign out_valid   = vld_q[2];
    assign lo_phase    = phase_q;
    assign commit_done = commit_done_q;
    assign wl_err      = wl_err_q;

endmodule

// File: tb/tb_bf_array_core.sv
// Directed bench for bf_array_core built with six channels so an out-of-range
// channel address is reachable; expected mix values are hand-computed.
module tb_bf_array_core;

    localparam int N_CH  = 6;
    localparam int N_SRC = 2;
    localparam int IN_W  = 8;
    localparam int W_W   = 5;
    localparam int OUT_W = 20;
    localparam int CH_W  = 3;
    localparam int SRC_W = 1;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  en;
    logic [N_SRC*IN_W-1:0] vin_i;
    logic [N_SRC*IN_W-1:0] vin_q;
    logic                  wl_valid;
    logic                  wl_ready;
    logic [CH_W-1:0]       wl_ch;
    logic [SRC_W-1:0]      wl_src;
    logic signed [W_W-1:0] wl_cos;
    logic signed [W_W-1:0] wl_sin;
    logic                  wl_commit;
    logic                  commit_done;
    logic                  wl_err;
    logic [N_CH*OUT_W-1:0] mix_o;
    logic                  out_valid;
    logic [1:0]            lo_phase;

    int checks = 0;
    int errors = 0;
    int lo_cnt = 0;
    int exp_phase = 0;

    int tbl0 [4] = '{150, 45, -150, -45};
    int tbl2 [4] = '{2032, 2048, -2032, -2048};
    int tbl3 [4] = '{-36, 11, 36, -11};

    bf_array_core #(
        .N_CH(N_CH), .N_SRC(N_SRC), .IN_W(IN_W), .W_W(W_W), .OUT_W(OUT_W)
    ) dut (
        .clock(clock), .reset(reset), .en(en),
        .vin_i(vin_i), .vin_q(vin_q),
        .wl_valid(wl_valid), .wl_ready(wl_ready),
        .wl_ch(wl_ch), .wl_src(wl_src), .wl_cos(wl_cos), .wl_sin(wl_sin),
        .wl_commit(wl_commit), .commit_done(commit_done), .wl_err(wl_err),
        .mix_o(mix_o), .out_valid(out_valid), .lo_phase(lo_phase)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int ch(input int c);
        logic signed [OUT_W-1:0] v;
        v = mix_o[c*OUT_W +: OUT_W];
        return int'(v);
    endfunction

    // Advances one clock and tracks the LO counter the DUT should hold.
    task automatic step();
        @(posedge clock);
        if (reset) begin
            lo_cnt = 0;
            exp_phase = 0;
        end else if (en) begin
            exp_phase = lo_cnt;
            lo_cnt = (lo_cnt + 1) % 4;
        end
        #1;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (commit_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1;
        vin_i = {8'h10, 8'h10}; vin_q = {8'h10, 8'h10};
        wl_valid = 1'b0; wl_ch = '0; wl_src = '0; wl_cos = '0; wl_sin = '0; wl_commit = 1'b0;
        step(); step();
        checks++;
        if (wl_ready !== 1'b0 || out_valid !== 1'b0 || commit_done !== 1'b0 ||
            wl_err !== 1'b0 || lo_phase !== 2'd0 || mix_o !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: ready=%b valid=%b done=%b err=%b phase=%0d mix=%h required all zero",
                     wl_ready, out_valid, commit_done, wl_err, lo_phase, mix_o);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (wl_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_reset: got %b required 1", wl_ready);
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (out_valid !== (i >= 3) || lo_phase !== 2'(i - 1) || mix_o !== '0) begin
                errors++;
                $display("[TB] FAIL fill_cycle%0d: valid=%b phase=%0d mix=%h required valid=%0d phase=%0d mix=0",
                         i, out_valid, lo_phase, mix_o, (i >= 3), i - 1);
            end
        end
    endtask

    task automatic test_load_single();
        bit seen;
        vin_i = {8'd0, 8'd10}; vin_q = {8'd0, 8'd3};
        wl_valid = 1'b1; wl_ch = 3'd0; wl_src = 1'b0; wl_cos = 5'sd15; wl_sin = 5'sd0;
        step();
        wl_valid = 1'b0;
        checks++;
        if (wl_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_on_valid_write: got %b required 0", wl_err);
        end
        wl_commit = 1'b1;
        step();
        wl_commit = 1'b0;
        wait_done(seen);
        checks++;
        if (seen !== 1'b1 || lo_phase !== 2'd3) begin
            errors++;
            $display("[TB] FAIL commit_align: done_seen=%b lo_phase=%0d required done_seen=1 lo_phase=3",
                     seen, lo_phase);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (ch(0) !== tbl0[i] || ch(1) !== 0 || ch(2) !== 0 || ch(3) !== 0 ||
                ch(4) !== 0 || ch(5) !== 0) begin
                errors++;
                $display("[TB] FAIL ch0_seq%0d: ch0=%0d others=%0d,%0d,%0d,%0d,%0d required ch0=%0d others 0",
                         i, ch(0), ch(1), ch(2), ch(3), ch(4), ch(5), tbl0[i]);
            end
        end
    endtask

    task automatic test_load_negative();
        bit seen;
        vin_i = {8'h80, 8'd10}; vin_q = {8'h7F, 8'd3};
        wl_valid = 1'b1; wl_ch = 3'd2; wl_src = 1'b1; wl_cos = 5'sd0; wl_sin = 5'b10000;
        step();
        wl_valid = 1'b0;
        wl_commit = 1'b1;
        step();
        wl_commit = 1'b0;
        wait_done(seen);
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("[TB] FAIL commit2_done: got %b required 1", seen);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (ch(2) !== tbl2[i] || ch(0) !== tbl0[i]) begin
                errors++;
                $display("[TB] FAIL ch2_seq%0d: ch2=%0d ch0=%0d required ch2=%0d ch0=%0d",
                         i, ch(2), ch(0), tbl2[i], tbl0[i]);
            end
        end
    endtask

    task automatic test_commit_boundary();
        int pend = 0;
        int dones = 0;
        int bad = 0;
        for (int i = 0; i < 4 && lo_cnt != 3; i++) step();
        wl_commit = 1'b1;
        step();
        wl_commit = 1'b0;
        wl_ch = 3'd1; wl_src = 1'b0; wl_cos = 5'sd7; wl_sin = 5'sd0;
        for (int i = 0; i < 8; i++) begin
            if (wl_ready === 1'b0) pend++;
            if (commit_done === 1'b1) dones++;
            wl_valid = (wl_ready === 1'b0);
            step();
        end
        wl_valid = 1'b0;
        checks++;
        if (pend !== 4) begin
            errors++;
            $display("[TB] FAIL pend_cycles: got %0d required 4", pend);
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("[TB] FAIL commit_count: got %0d required 1", dones);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (ch(1) !== 0 || ch(2) !== tbl2[exp_phase]) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL pend_write_blocked: %0d bad cycles, ch1=%0d ch2=%0d required ch1=0 ch2=%0d",
                     bad, ch(1), ch(2), tbl2[exp_phase]);
        end
    endtask

    task automatic test_stall();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (lo_phase !== 2'(exp_phase) || out_valid !== 1'b1 ||
                ch(2) !== tbl2[exp_phase] || ch(0) !== tbl0[exp_phase]) begin
                errors++;
                $display("[TB] FAIL stall%0d: phase=%0d valid=%b ch2=%0d ch0=%0d required phase=%0d valid=1 ch2=%0d ch0=%0d",
                         i, lo_phase, out_valid, ch(2), ch(0), exp_phase, tbl2[exp_phase], tbl0[exp_phase]);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (lo_phase !== 2'(exp_phase) || ch(2) !== tbl2[exp_phase]) begin
                errors++;
                $display("[TB] FAIL resume%0d: phase=%0d ch2=%0d required phase=%0d ch2=%0d",
                         i, lo_phase, ch(2), exp_phase, tbl2[exp_phase]);
            end
        end
    endtask

    task automatic test_err_and_write_commit();
        bit seen;
        wl_valid = 1'b1; wl_ch = 3'd6; wl_src = 1'b0; wl_cos = 5'sd5; wl_sin = 5'sd5;
        step();
        wl_valid = 1'b0;
        checks++;
        if (wl_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_pulse: got %b required 1", wl_err);
        end
        step();
        checks++;
        if (wl_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_one_cycle: got %b required 0", wl_err);
        end
        wl_valid = 1'b1; wl_commit = 1'b1;
        wl_ch = 3'd3; wl_src = 1'b0; wl_cos = 5'b11101; wl_sin = 5'sd2;
        step();
        wl_valid = 1'b0; wl_commit = 1'b0;
        wait_done(seen);
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("[TB] FAIL commit3_done: got %b required 1", seen);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (ch(3) !== tbl3[i] || ch(1) !== 0 || ch(4) !== 0 || ch(5) !== 0) begin
                errors++;
                $display("[TB] FAIL ch3_seq%0d: ch3=%0d ch1=%0d ch4=%0d ch5=%0d required ch3=%0d others 0",
                         i, ch(3), ch(1), ch(4), ch(5), tbl3[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_single();
        test_load_negative();
        test_commit_boundary();
        test_stall();
        test_err_and_write_commit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
